menu_draw_char: RTL and testbench
=================================

Name: menu_draw_char

Overview:
- Pixel-stream stage that overlays the 16x4-character menu text box onto the VGA stream.
- Converts the current hcount/vcount into the character cell address `char_xy` and feeds the menu text ROM.
- Builds the font-ROM line address from the returned `char_code`, then paints font pixels in TEXT_COLOR.
- Delays all timing signals so the outputs stay aligned.

Parameters:
- X_POS, 11'd100, left pixel column of the text box.
- Y_POS, 11'd50, top pixel line of the text box.
- TEXT_COLOR, 12'hF_F_F, rgb of a lit font pixel.
- BG_EN, 1'b0, 1 = fill unlit pixels inside the box with BG_COLOR.
- BG_COLOR, 12'h0_0_0, box background when BG_EN=1.

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, synchronous active-high reset.
- hcount_in, input, 11, horizontal pixel counter.
- vcount_in, input, 11, vertical line counter.
- hsync_in, input, 1, horizontal sync.
- vsync_in, input, 1, vertical sync.
- hblnk_in, input, 1, horizontal blank.
- vblnk_in, input, 1, vertical blank.
- rgb_in, input, 12, background pixel colour.
- char_xy, output, 8, {row[3:0], col[3:0]} cell address to the text ROM.
- char_code, input, 7, glyph code from the text ROM, registered there: valid 1 cycle after char_xy.
- char_line, output, 11, font ROM address {char_code, line[3:0]}.
- char_pixels, input, 8, font ROM row, registered there: valid 1 cycle after char_line. Bit 7 = leftmost pixel.
- hcount_out, vcount_out, output, 11 each, delayed counters.
- hsync_out, vsync_out, hblnk_out, vblnk_out, output, 1 each, delayed timing.
- rgb_out, output, 12, composited pixel.

Behaviour:
- Geometry: characters are 8x16 px. The box spans hcount X_POS..X_POS+127 and vcount Y_POS..Y_POS+63.
- in_box = (hcount_in >= X_POS) && (hcount_in < X_POS+128) && (vcount_in >= Y_POS) && (vcount_in < Y_POS+64). All comparisons are unsigned 11-bit; no wrap (X_POS+128 must be ≤ 2047).
- rel_x = hcount_in - X_POS; rel_y = vcount_in - Y_POS.
- Pipeline stage S1, cycle t+1:
  - char_xy <= {rel_y[5:4], rel_y[5:4] zero-extended to 4 bits as row, rel_x[6:3] as col}, i.e. char_xy = {2'b00, rel_y[5:4], rel_x[6:3]}.
  - Also registered: in_box, rel_x[2:0], rel_y[3:0].
  - When not in_box, char_xy <= 8'h00; the value is don't-care downstream but deterministic.
- S2, cycle t+2: char_code is valid. char_line = {char_code, line_d2} is combinational from char_code and the registered line. Register in_box_d2 and bitpos_d2.
- S3, cycle t+3: char_pixels is valid. Register in_box_d3 and bitpos_d3.
- S4, cycle t+4: outputs registered.
  - pix = char_pixels[7 - bitpos_d3].
  - If hblnk_d3 or vblnk_d3: rgb_out <= rgb_d3 (pass).
  - Else if in_box_d3 && pix: rgb_out <= TEXT_COLOR.
  - Else if in_box_d3 && BG_EN: rgb_out <= BG_COLOR.
  - Else: rgb_out <= rgb_d3.
- Total latency is 4 cycles, input to all outputs. hcount/vcount/sync/blank/rgb pass through a 4-deep shift chain: x_out(t+4) = x_in(t).
- Reset: every pipeline register clears to 0, and all outputs (char_xy, counters, syncs, blanks, rgb_out) read 0 on the cycle after rst is sampled high. char_line then reads {char_code, 4'h0}.
- Reset mid-frame: the pipeline flushes to zeros. After rst deasserts, outputs reflect the stream 4 cycles later; no stale pixels emitted.
- Box edges:
  - hcount = X_POS-1 and X_POS+128 are outside.
  - hcount = X_POS+127 is col 15, bit 0.
  - vcount = Y_POS+63 is row 3, line 15.
- Blanking overrides the box even if the box is placed in the blank region.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all outputs 0; release, drive hcount=5 -> hcount_out=5 exactly 4 cycles later.
- Cell addressing (X_POS=100, Y_POS=50): hcount=108, vcount=50 -> char_xy=8'h01 at t+1. hcount=227, vcount=113 -> char_xy=8'h3F at t+1.
- Font line: model ROM with char_code=7'h41 at t+2, vcount=Y_POS+5 -> char_line=11'h415 at t+2.
- Pixel select: char_pixels=8'b1000_0000 over hcount 108..115, rgb_in=12'h123 -> rgb_out=TEXT_COLOR only for hcount_out=108, 12'h123 for 109..115.
- Edges/BG (BG_EN=1, BG_COLOR=12'h00F, char_pixels=0): hcount 99 -> rgb_in; 100 and 227 -> 12'h00F; 228 -> rgb_in. Same check on vcount 49/50/113/114.
- Blank override: box region with hblnk_in=1, char_pixels=8'hFF -> rgb_out=rgb_in delayed, never TEXT_COLOR. Sync/blank outputs are exact 4-cycle copies across a full line.

Source files
------------

// File: rtl/menu_draw_char.sv
// menu_draw_char: overlays the 16x4-character menu text box on the VGA stream.
// Four-cycle pipeline: cell address, font address, font row, composite.
module menu_draw_char #(
   parameter logic [10:0] X_POS      = 11'd100,
   parameter logic [10:0] Y_POS      = 11'd50,
   parameter logic [11:0] TEXT_COLOR = 12'hF_F_F,
   parameter logic        BG_EN      = 1'b0,
   parameter logic [11:0] BG_COLOR   = 12'h0_0_0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   output logic [7:0]  char_xy,
   input  logic [6:0]  char_code,
   output logic [10:0] char_line,
   input  logic [7:0]  char_pixels,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   logic [6:0] rel_x;
   logic [5:0] rel_y;
   logic       in_box;

   // Only the low bits of the box-relative offsets are ever needed.
   always_comb begin
      rel_x  = 7'(hcount_in - X_POS);
      rel_y  = 6'(vcount_in - Y_POS);
      in_box = (hcount_in >= X_POS) && (hcount_in < X_POS + 11'd128)
            && (vcount_in >= Y_POS) && (vcount_in < Y_POS + 11'd64);
   end

   logic [2:0]       in_box_d;
   logic [2:0]       bitpos_d1, bitpos_d2, bitpos_d3;
   logic [3:0]       line_d1, line_d2;
   logic [2:0][10:0] hcount_d, vcount_d;
   logic [2:0][3:0]  timing_d;
   logic [2:0][11:0] rgb_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         char_xy   <= '0;
         in_box_d  <= '0;
         bitpos_d1 <= '0;
         bitpos_d2 <= '0;
         bitpos_d3 <= '0;
         line_d1   <= '0;
         line_d2   <= '0;
         hcount_d  <= '0;
         vcount_d  <= '0;
         timing_d  <= '0;
         rgb_d     <= '0;
      end else begin
         char_xy   <= in_box ? {2'b00, rel_y[5:4], rel_x[6:3]} : 8'h00;
         in_box_d  <= {in_box_d[1:0], in_box};
         bitpos_d1 <= rel_x[2:0];
         bitpos_d2 <= bitpos_d1;
         bitpos_d3 <= bitpos_d2;
         line_d1   <= rel_y[3:0];
         line_d2   <= line_d1;
         hcount_d  <= {hcount_d[1:0], hcount_in};
         vcount_d  <= {vcount_d[1:0], vcount_in};
         timing_d  <= {timing_d[1:0],
                       {hsync_in, vsync_in, hblnk_in, vblnk_in}};
         rgb_d     <= {rgb_d[1:0], rgb_in};
      end
   end

   assign char_line = {char_code, line_d2};

   logic        pix;
   logic        blank;
   logic [11:0] rgb_next;

   // Blanking wins over the box so sync regions are never painted.
   always_comb begin
      pix      = char_pixels[3'd7 - bitpos_d3];
      blank    = timing_d[2][1] | timing_d[2][0];
      rgb_next = rgb_d[2];
      if (!blank && in_box_d[2]) begin
         if (pix)
            rgb_next = TEXT_COLOR;
         else if (BG_EN)
            rgb_next = BG_COLOR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= hcount_d[2];
         vcount_out <= vcount_d[2];
         {hsync_out, vsync_out, hblnk_out, vblnk_out} <= timing_d[2];
         rgb_out    <= rgb_next;
      end
   end

endmodule

// File: tb/tb_menu_draw_char.sv
// tb_menu_draw_char: randomized bench with ROM models and a pixel-level
// reference of the text box, run on a plain and a background-fill instance.
module tb_menu_draw_char;

   localparam int X = 100;
   localparam int Y = 50;
   localparam logic [11:0] TC0 = 12'hFFF;
   localparam logic [11:0] TC1 = 12'hE5A;
   localparam logic [11:0] BG1 = 12'h00F;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in;

   logic [7:0]  xy0, xy1;
   logic [6:0]  code0 = '0, code1 = '0;
   logic [10:0] line0, line1;
   logic [7:0]  pix0 = '0, pix1 = '0;
   logic [10:0] hco0, vco0, hco1, vco1;
   logic        hs0, vs0, hb0, vb0, hs1, vs1, hb1, vb1;
   logic [11:0] rgbo0, rgbo1;

   logic [6:0]  text_rom [256];
   logic [7:0]  font_rom [2048];

   int checks = 0;
   int errors = 0;

   logic [37:0] q0 [$];
   logic [37:0] q1 [$];

   wire [37:0] obs0 = {hco0, vco0, hs0, vs0, hb0, vb0, rgbo0};
   wire [37:0] obs1 = {hco1, vco1, hs1, vs1, hb1, vb1, rgbo1};

   always #5 clk = ~clk;

   menu_draw_char dut0 (
      .clk(clk), .rst(rst),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in),
      .char_xy(xy0), .char_code(code0),
      .char_line(line0), .char_pixels(pix0),
      .hcount_out(hco0), .vcount_out(vco0),
      .hsync_out(hs0), .vsync_out(vs0),
      .hblnk_out(hb0), .vblnk_out(vb0),
      .rgb_out(rgbo0)
   );

   menu_draw_char #(
      .TEXT_COLOR(TC1), .BG_EN(1'b1), .BG_COLOR(BG1)
   ) dut1 (
      .clk(clk), .rst(rst),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in),
      .char_xy(xy1), .char_code(code1),
      .char_line(line1), .char_pixels(pix1),
      .hcount_out(hco1), .vcount_out(vco1),
      .hsync_out(hs1), .vsync_out(vs1),
      .hblnk_out(hb1), .vblnk_out(vb1),
      .rgb_out(rgbo1)
   );

   // Registered text and font ROMs, one read port per instance.
   always @(posedge clk) begin
      code0 <= text_rom[xy0];
      code1 <= text_rom[xy1];
      pix0  <= font_rom[line0];
      pix1  <= font_rom[line1];
   end

   function automatic logic [11:0] model_rgb(
      input int h, input int v, input logic hb, input logic vb,
      input logic [11:0] c, input bit bg,
      input logic [11:0] tc, input logic [11:0] bc);
      int rx, ry, code;
      logic [7:0] row;
      if (hb || vb) return c;
      if (h < X || h >= X + 128 || v < Y || v >= Y + 64) return c;
      rx = h - X;
      ry = v - Y;
      code = int'(text_rom[(ry / 16) * 16 + rx / 8]);
      row = font_rom[code * 16 + ry % 16];
      if (row[7 - rx % 8]) return tc;
      return bg ? bc : c;
   endfunction

   function automatic logic [7:0] model_xy(input int h, input int v);
      if (h < X || h >= X + 128 || v < Y || v >= Y + 64) return 8'h00;
      return 8'(((v - Y) / 16) * 16 + (h - X) / 8);
   endfunction

   task automatic fill_rom();
      for (int i = 0; i < 256; i++) text_rom[i] = 7'($urandom);
      for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
   endtask

   // Drives one pixel, advances a clock and returns the sample leaving now.
   task automatic tick(
      input logic r, input logic [10:0] h, input logic [10:0] v,
      input logic [3:0] tim, input logic [11:0] c,
      output bit have, output logic [37:0] e0, output logic [37:0] e1);
      rst = r;
      hcount_in = h;
      vcount_in = v;
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = tim;
      rgb_in = c;
      if (!r) begin
         q0.push_back({h, v, tim, model_rgb(int'(h), int'(v), tim[1],
                       tim[0], c, 1'b0, TC0, 12'h000)});
         q1.push_back({h, v, tim, model_rgb(int'(h), int'(v), tim[1],
                       tim[0], c, 1'b1, TC1, BG1)});
      end
      @(posedge clk);
      #1;
      have = 1'b0;
      e0 = '0;
      e1 = '0;
      if (r) begin
         q0.delete();
         q1.delete();
         repeat (3) begin
            q0.push_back('0);
            q1.push_back('0);
         end
      end else if (q0.size() == 4) begin
         e0 = q0.pop_front();
         e1 = q1.pop_front();
         have = 1'b1;
      end
   endtask

   task automatic test_reset();
      bit have;
      logic [37:0] e0, e1;
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 11'($urandom), 11'($urandom), 4'($urandom),
              12'($urandom), have, e0, e1);
         checks++;
         if (obs0 !== '0 || obs1 !== '0 || xy0 !== '0 || xy1 !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h %h xy %h %h want 0",
                     obs0, obs1, xy0, xy1);
         end
         checks++;
         if (line0 !== {code0, 4'h0}) begin
            errors++;
            $display("FAIL reset_char_line got %h want %h",
                     line0, {code0, 4'h0});
         end
      end
      for (int k = 0; k < 5; k++) begin
         tick(1'b0, (k == 0) ? 11'd5 : 11'd9, 11'd0, 4'b0000, 12'h000,
              have, e0, e1);
         if (have) begin
            checks++;
            if (obs0 !== e0 || obs1 !== e1) begin
               errors++;
               $display("FAIL reset_release k=%0d got %h %h want %h %h",
                        k, obs0, obs1, e0, e1);
            end
         end
         if (k == 3) begin
            checks++;
            if (hco0 !== 11'd5) begin
               errors++;
               $display("FAIL reset_latency got %0d want 5", hco0);
            end
         end
      end
   endtask

   task automatic test_addressing();
      bit have;
      logic [37:0] e0, e1;
      int hs [4] = '{108, 227, 99, 228};
      int vs [4] = '{50, 113, 50, 50};
      logic [7:0] xs [4] = '{8'h01, 8'h3F, 8'h00, 8'h00};
      int h, v;
      logic [7:0] exy;
      for (int k = 0; k < 48; k++) begin
         if (k < 4) begin
            h = hs[k];
            v = vs[k];
            exy = xs[k];
         end else begin
            h = int'($urandom_range(80, 250));
            v = int'($urandom_range(40, 120));
            exy = model_xy(h, v);
         end
         tick(1'b0, 11'(h), 11'(v), 4'($urandom_range(0, 12)),
              12'($urandom), have, e0, e1);
         checks++;
         if (xy0 !== exy || xy1 !== exy) begin
            errors++;
            $display("FAIL char_xy h=%0d v=%0d got %h %h want %h",
                     h, v, xy0, xy1, exy);
         end
         if (have) begin
            checks++;
            if (obs0 !== e0 || obs1 !== e1) begin
               errors++;
               $display("FAIL addr_stream got %h %h want %h %h",
                        obs0, obs1, e0, e1);
            end
         end
      end
   endtask

   task automatic test_font_line();
      bit have;
      logic [37:0] e0, e1;
      repeat (4) tick(1'b0, 11'd0, 11'd0, 4'b0010, 12'h0, have, e0, e1);
      text_rom[8'h01] = 7'h41;
      tick(1'b0, 11'd108, 11'(Y + 5), 4'b0000, 12'h321, have, e0, e1);
      tick(1'b0, 11'd0, 11'd0, 4'b0010, 12'h0, have, e0, e1);
      checks++;
      if (line0 !== 11'h415 || line1 !== 11'h415) begin
         errors++;
         $display("FAIL char_line got %h %h want 415", line0, line1);
      end
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 11'd0, 11'd0, 4'b0010, 12'h0, have, e0, e1);
         if (have) begin
            checks++;
            if (obs0 !== e0 || obs1 !== e1) begin
               errors++;
               $display("FAIL font_stream got %h %h want %h %h",
                        obs0, obs1, e0, e1);
            end
         end
      end
   endtask

   task automatic test_pixel_select();
      bit have;
      logic [37:0] e0, e1;
      logic [11:0] want;
      for (int c = 0; c < 128; c++) font_rom[c * 16] = 8'h80;
      for (int k = 0; k < 12; k++) begin
         if (k < 8)
            tick(1'b0, 11'(108 + k), 11'd50, 4'b0000, 12'h123,
                 have, e0, e1);
         else
            tick(1'b0, 11'd0, 11'd0, 4'b0010, 12'h0, have, e0, e1);
         if (have) begin
            checks++;
            if (obs0 !== e0 || obs1 !== e1) begin
               errors++;
               $display("FAIL pix_stream got %h %h want %h %h",
                        obs0, obs1, e0, e1);
            end
         end
         if (k >= 3 && k < 11) begin
            want = (k == 3) ? TC0 : 12'h123;
            checks++;
            if (rgbo0 !== want) begin
               errors++;
               $display("FAIL pix_select h=%0d got %h want %h",
                        105 + k, rgbo0, want);
            end
         end
      end
   endtask

   task automatic test_edges();
      bit have;
      logic [37:0] e0, e1;
      int hs [8] = '{99, 100, 227, 228, 150, 150, 150, 150};
      int vs [8] = '{60, 60, 60, 60, 49, 50, 113, 114};
      bit ins [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
      logic [11:0] cs [8];
      logic [11:0] want;
      for (int i = 0; i < 2048; i++) font_rom[i] = 8'h00;
      for (int i = 0; i < 8; i++) cs[i] = 12'($urandom_range(16, 4095));
      for (int k = 0; k < 12; k++) begin
         if (k < 8)
            tick(1'b0, 11'(hs[k]), 11'(vs[k]), 4'b0000, cs[k],
                 have, e0, e1);
         else
            tick(1'b0, 11'd0, 11'd0, 4'b0010, 12'h0, have, e0, e1);
         if (have) begin
            checks++;
            if (obs0 !== e0 || obs1 !== e1) begin
               errors++;
               $display("FAIL edge_stream got %h %h want %h %h",
                        obs0, obs1, e0, e1);
            end
         end
         if (k >= 3 && k < 11) begin
            want = ins[k - 3] ? BG1 : cs[k - 3];
            checks++;
            if (rgbo1 !== want || rgbo0 !== cs[k - 3]) begin
               errors++;
               $display("FAIL edge h=%0d v=%0d got %h %h want %h %h",
                        hs[k - 3], vs[k - 3], rgbo1, rgbo0, want,
                        cs[k - 3]);
            end
         end
      end
      fill_rom();
   endtask

   task automatic test_blank();
      bit have;
      logic [37:0] e0, e1;
      logic [3:0] tim;
      for (int i = 0; i < 2048; i++) font_rom[i] = 8'hFF;
      for (int h = 0; h < 304; h++) begin
         tim = {h >= 270 && h < 286, 1'b0,
                h >= 256 || (h >= 150 && h < 180), 1'b0};
         if (h >= 300) tim = 4'b0010;
         tick(1'b0, 11'(h), 11'd60, tim, 12'($urandom) & 12'h7FF,
              have, e0, e1);
         if (have) begin
            checks++;
            if (obs0 !== e0 || obs1 !== e1) begin
               errors++;
               $display("FAIL blank_stream got %h %h want %h %h",
                        obs0, obs1, e0, e1);
            end
            if (e0[13]) begin
               checks++;
               if (rgbo0 !== e0[11:0] || rgbo1 !== e0[11:0]) begin
                  errors++;
                  $display("FAIL blank_override got %h %h want %h",
                           rgbo0, rgbo1, e0[11:0]);
               end
            end
         end
      end
      fill_rom();
   endtask

   task automatic test_random();
      bit have;
      logic [37:0] e0, e1;
      logic r;
      for (int k = 0; k < 400; k++) begin
         r = (k == 200 || k == 201);
         tick(r, 11'($urandom_range(90, 240)), 11'($urandom_range(40, 120)),
              {2'($urandom), $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0},
              12'($urandom), have, e0, e1);
         if (r || have) begin
            checks++;
            if (obs0 !== e0 || obs1 !== e1) begin
               errors++;
               $display("FAIL random k=%0d got %h %h want %h %h",
                        k, obs0, obs1, e0, e1);
            end
         end
      end
   endtask

   initial begin
      fill_rom();
      test_reset();
      test_addressing();
      test_font_line();
      test_pixel_select();
      test_edges();
      test_blank();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
